// File: rtl/apb_master_pkg.sv
// Shared types and register map for the APB initiator of the I2C register bridge.
// Holds the controller state encoding and the captured response layout.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int APB_DATA_W = 32;

    localparam logic [31:0] ADDR_TX_FIFO     = 32'h0000_0000;
    localparam logic [31:0] ADDR_RX_FIFO     = 32'h0000_0004;
    localparam logic [31:0] ADDR_I2C_CONFIG  = 32'h0000_0008;
    localparam logic [31:0] ADDR_I2C_TIMEOUT = 32'h0000_000C;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-state counter; cleared in SETUP, counts PREADY-low cycles, saturates.
// expired is combinational on pready so the controller can abort on the final allowed cycle.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    input  logic inc,
    input  logic pready,
    output logic expired
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CNT_LAST) && !pready;

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB initiator: command -> SETUP -> ACCESS -> response, 3 cycles at zero wait.
// cmd_ready only in IDLE; a response is held stable until rsp_ready; ACCESS aborts after TIMEOUT_CYCLES.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    rsp_t              rsp_q, rsp_d;
    logic              rsp_capture;
    logic              timer_clr, timer_inc, timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .pready  (PREADY),
        .expired (timer_expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (rsp_capture) begin
                rsp_q <= rsp_d;
            end
        end
    end

    // APB inputs only steer next-state and the response capture, never an output directly.
    always_comb begin
        state_d     = state_q;
        rsp_d       = rsp_q;
        rsp_capture = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        PSELx       = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        rsp_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                PSELx     = 1'b1;
                PWRITE    = write_q;
                PADDR     = addr_q;
                PWDATA    = write_q ? wdata_q : '0;
                timer_clr = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                PWRITE  = write_q;
                PADDR   = addr_q;
                PWDATA  = write_q ? wdata_q : '0;
                if (PREADY) begin
                    rsp_capture   = 1'b1;
                    rsp_d.rdata   = write_q ? '0 : APB_DATA_W'(PRDATA);
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (timer_expired) begin
                    rsp_capture   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = DATA_W'(rsp_q.rdata);
                rsp_err     = rsp_q.err;
                rsp_timeout = rsp_q.timeout;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
APB initiator for the I2C register bridge. It accepts single register commands (write or read) on a valid/ready interface and runs each command as a two-phase APB transfer: SETUP, then ACCESS. It returns read data and error status on a response handshake. An ACCESS phase that never completes is aborted by a wait-state timeout. It sits between the host-side command sequencer and the APB responder that fronts the I2C core.

Parameters:
TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY before abort (legal range 2..1024)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESETn  in  1  synchronous reset, active-high (1 = reset)
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by the timeout
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error
busy  out  1  state is not IDLE

Behaviour:
- Reset: state goes to IDLE. All outputs are 0 except cmd_ready, which is 1. The wait counter and captured command/response registers are cleared.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state only. There is no combinational path from APB inputs to outputs.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, capture write/addr/wdata and go to SETUP.
  - cmd_ready=0 in every other state.
- SETUP (exactly 1 cycle):
  - PSELx=1, PENABLE=0.
  - PADDR/PWRITE come from the captured command.
  - PWDATA = captured wdata for a write, 0 for a read.
  - Next state is ACCESS; clear the wait counter.
- ACCESS:
  - PSELx=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - PREADY=1 at a clock edge: sample PSLVERR into rsp_err, and PRDATA into rsp_rdata for reads only (writes give 0). Set rsp_timeout=0 and go to RESP.
  - PREADY=0: increment the wait counter.
  - Timeout: if PREADY is still 0 when the counter = TIMEOUT_CYCLES-1, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0. ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - PSLVERR and PRDATA are ignored while PREADY=0.
- RESP:
  - PSELx=PENABLE=0; PADDR/PWRITE/PWDATA=0.
  - rsp_valid=1 with stable data until rsp_ready=1, then go to IDLE.
  - rsp_ready may be held high; a response is still presented for at least one cycle.
- Latency: with a zero-wait responder and rsp_ready held at 1, command accept to rsp_valid is 3 cycles. Minimum spacing between accepted commands is 4 cycles.
- No pipelining: exactly one transfer is outstanding. A new command is never accepted while rsp_valid=1.
- Reset mid-operation: the bus is released (PSELx/PENABLE=0) on the next edge and no response is produced. A pending response is discarded.
- busy=1 in SETUP, ACCESS and RESP.
- Wait counter width: $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Decomposition:
- Package apb_master_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - register map constants ADDR_TX_FIFO=0x0, ADDR_RX_FIFO=0x4, ADDR_I2C_CONFIG=0x8, ADDR_I2C_TIMEOUT=0xC;
  - response-struct typedef (rdata, err, timeout).
- Sub-module apb_wait_timer: wait counter with clear, increment and expired output (expired = count==TIMEOUT_CYCLES-1 & ~PREADY).

Test Plan:
- Write 0x8 / 0x0000_1A2B, zero-wait responder -> SETUP 1 cycle with PSELx=1 and PENABLE=0; ACCESS 1 cycle with PWDATA=0x1A2B; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read 0x4, responder inserts 3 wait states then returns PRDATA=0xDEAD_BEEF -> ACCESS 4 cycles; rsp_rdata=0xDEADBEEF; PADDR stable throughout.
- Read 0x10, responder never asserts PREADY, TIMEOUT_CYCLES=16 -> PENABLE high exactly 16 cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; bus idle afterwards.
- Write 0x0 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0. A following write to 0xC / 0x0064 completes with rsp_err=0.
- rsp_ready held 0 for 5 cycles, cmd_valid held 1 with the next command -> cmd_ready stays 0 and the response stays stable. After rsp_ready, IDLE for 1 cycle, then the next command is accepted and its SETUP starts.
- PRESETn=1 asserted during ACCESS -> next edge PSELx=PENABLE=0 and rsp_valid=0; after release a fresh write to 0x8 completes normally.
